// File: rtl/spi_master_mc.sv
// SPI master with a byte-wide register interface: runtime SCLK divider, all four
// SPI modes, selectable bit order, one-byte transmit holding buffer, rx valid/overrun flags.
module spi_master_mc #(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int SCLK_FREQ = 1_000_000,
  parameter int NUM_SS    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_wr,
  input  logic [3:0]        i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_SCLK,
  output logic              o_MOSI,
  input  logic              i_MISO,
  output logic [NUM_SS-1:0] o_SS_bar
);

  localparam int DIV_RAW     = CLK_FREQ / (2 * SCLK_FREQ) - 1;
  localparam int DIV_CLAMPED = (DIV_RAW < 0) ? 0 : ((DIV_RAW > 255) ? 255 : DIV_RAW);
  localparam logic [7:0] DIV_RST = 8'(DIV_CLAMPED);

  localparam logic [3:0] A_STATUS   = 4'h0;
  localparam logic [3:0] A_DATA_OUT = 4'h1;
  localparam logic [3:0] A_DATA_IN  = 4'h2;
  localparam logic [3:0] A_CTRL     = 4'h3;
  localparam logic [3:0] A_DIV      = 4'h4;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [6:0]  ctrl_q, ctrl_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  txbuf_q, txbuf_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  rx_q, rx_d;
  logic        rx_valid_q, rx_valid_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  edge_q, edge_d;
  logic        cpha_q, cpha_d;
  logic        lsb_q, lsb_d;
  logic [7:0]  xdiv_q, xdiv_d;

  logic        wr_en, rd_en, rd_data_in, busy, load, tick, sample, advance;
  logic [7:0]  rd_mux;

  function automatic logic first_bit(input logic [7:0] b, input logic lsb);
    return lsb ? b[0] : b[7];
  endfunction

  function automatic logic [7:0] drop_bit(input logic [7:0] b, input logic lsb);
    return lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  assign wr_en      = i_en & i_wr;
  assign rd_en      = i_en & ~i_wr;
  assign rd_data_in = rd_en && (i_addr == A_DATA_IN);
  assign busy       = (state_q != S_IDLE);
  assign load       = (state_q == S_IDLE) && tx_full_q;
  assign tick       = (state_q == S_SHIFT) && (cnt_q == xdiv_q);
  // Tick n is edge_q+1: odd ticks have edge_q[0]==0.
  assign sample     = tick && (cpha_q ? edge_q[0] : ~edge_q[0]);
  assign advance    = tick && (cpha_q ? ~edge_q[0] : (edge_q[0] && edge_q != 4'd15));

  always_comb begin
    rd_mux = 8'h00;
    case (i_addr)
      A_STATUS:   rd_mux = {4'b0000, ovr_q, rx_valid_q, tx_full_q, busy};
      A_DATA_OUT: rd_mux = txbuf_q;
      A_DATA_IN:  rd_mux = rx_q;
      A_CTRL:     rd_mux = {1'b0, ctrl_q};
      A_DIV:      rd_mux = div_q;
      default:    rd_mux = 8'h00;
    endcase
  end

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    txbuf_d    = txbuf_q;
    tx_full_d  = tx_full_q;
    rx_d       = rx_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = ovr_q;
    rdata_d    = rd_en ? rd_mux : rdata_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    xdiv_d     = xdiv_q;

    if (rd_data_in) rx_valid_d = 1'b0;
    if (wr_en) begin
      case (i_addr)
        A_STATUS: if (i_data[3]) ovr_d = 1'b0;
        A_CTRL:   ctrl_d = i_data[6:0];
        A_DIV:    div_d  = i_data;
        default:  ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (tx_full_q) begin
          tx_full_d = 1'b0;
          cpha_d    = ctrl_q[0];
          lsb_d     = ctrl_q[3];
          xdiv_d    = div_q;
          cnt_d     = 8'd0;
          edge_d    = 4'd0;
          sclk_d    = ctrl_q[1];
          // CPHA=0 puts the first bit out before the first SCLK edge.
          if (!ctrl_q[0]) begin
            mosi_d  = first_bit(txbuf_q, ctrl_q[3]);
            tx_sh_d = drop_bit(txbuf_q, ctrl_q[3]);
          end else begin
            tx_sh_d = txbuf_q;
          end
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd15) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (sample) rx_sh_d = lsb_q ? {i_MISO, rx_sh_q[7:1]} : {rx_sh_q[6:0], i_MISO};
        if (advance) begin
          mosi_d  = first_bit(tx_sh_q, lsb_q);
          tx_sh_d = drop_bit(tx_sh_q, lsb_q);
        end
      end
      S_DONE: begin
        rx_d       = rx_sh_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q && !rd_data_in) ovr_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Evaluated after the FSM so a write can refill the buffer on the load edge.
    if (wr_en && i_addr == A_DATA_OUT && (!tx_full_q || load)) begin
      txbuf_d   = i_data;
      tx_full_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 7'd0;
      div_q      <= DIV_RST;
      txbuf_q    <= 8'd0;
      tx_full_q  <= 1'b0;
      rx_q       <= 8'd0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      rdata_q    <= 8'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      cnt_q      <= 8'd0;
      edge_q     <= 4'd0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      xdiv_q     <= DIV_RST;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      txbuf_q    <= txbuf_d;
      tx_full_q  <= tx_full_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
      rdata_q    <= rdata_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      xdiv_q     <= xdiv_d;
    end
  end

  // Slave selects follow CTRL directly so software controls framing.
  always_comb begin
    o_SS_bar = '1;
    for (int k = 0; k < NUM_SS; k++) begin
      if (ctrl_q[2] && ctrl_q[6:4] == 3'(k)) o_SS_bar[k] = 1'b0;
    end
  end

  assign o_data = rdata_q;
  assign o_MOSI = mosi_q;
  assign o_SCLK = (state_q == S_IDLE) ? ctrl_q[1] : sclk_q;

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised, multi-slave SPI master with a byte-wide register interface on the CPU side. It adds a runtime clock divider, all four SPI modes, MSB- or LSB-first shifting, a one-byte transmit holding buffer for back-to-back transfers, and receive-valid and overrun flags. It sits on the CPU's device bus and drives up to 8 external SPI slaves.

Parameters:
CLK_FREQ, 48_000_000, system clock frequency in Hz.
SCLK_FREQ, 1_000_000, reset SCLK frequency; DIV reset value = CLK_FREQ/(2*SCLK_FREQ)-1, clamped to 0..255.
NUM_SS, 1, number of slave-select lines, 1..8.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_en  in  1  device enable (bus strobe)
i_wr  in  1  0: read, 1: write
i_addr  in  4  register address
i_data  in  8  write data
o_data  out  8  registered read data
o_SCLK  out  1  SPI clock
o_MOSI  out  1  master out, slave in
i_MISO  in  1  master in, slave out
o_SS_bar  out  NUM_SS  slave selects, active-low

Behaviour:
- Reset (async assert, sync release): CTRL=0, DIV=reset value, holding buffer empty, rx=0, all flags 0, o_data=0, o_SCLK=0, o_MOSI=0, o_SS_bar all 1, FSM=IDLE. Reset mid-transfer aborts immediately with no partial rx update.
- Registers:
  - 0x0 STATUS, read: b0 busy, b1 tx_full, b2 rx_valid, b3 rx_overrun, b7:4 = 0. Write with b3=1 clears overrun.
  - 0x1 DATA_OUT: write loads the holding buffer and sets tx_full. Read returns the last written byte.
  - 0x2 DATA_IN: read returns rx and clears rx_valid.
  - 0x3 CTRL, r/w: b0 CPHA, b1 CPOL, b2 SS enable, b3 LSB-first, b6:4 slave index, b7 reserved (reads 0).
  - 0x4 DIV, r/w: SCLK half-period = DIV+1 clocks.
  - Other addresses: reads return 0; writes are ignored.
- Bus timing:
  - o_data updates on the clock edge where i_en & !i_wr; it holds otherwise.
  - Writes take effect on the edge where i_en & i_wr.
- DATA_OUT write acceptance: accepted iff tx_full=0, or the FSM moves the holding buffer into the shifter on the same edge. Otherwise the write is dropped.
- Slave selects: o_SS_bar[k] is low iff CTRL.b2=1 and index==k. An index >= NUM_SS leaves all lines high. This output is combinational from CTRL, applies immediately, and is never toggled by the FSM.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: o_SCLK = CTRL.CPOL. If tx_full, then on the next edge:
    - shifter <= holding buffer, tx_full <= 0;
    - latch mode, bit order and DIV for the whole transfer;
    - edge count <= 0, divider count <= 0;
    - go to SHIFT.
    - Result: busy rises on the edge after the DATA_OUT write edge.
  - SHIFT:
    - A tick fires every DIV+1 clocks; each tick toggles o_SCLK. There are exactly 16 ticks.
    - CPHA=0: o_MOSI presents the first bit on entry to SHIFT. i_MISO is sampled on odd ticks (1,3,..15). o_MOSI advances on even ticks 2..14.
    - CPHA=1: o_MOSI advances on odd ticks and i_MISO is sampled on even ticks.
    - First bit is MSB, or LSB if LSB-first. Received bits are assembled in the same order.
    - After tick 16, o_SCLK has returned to CPOL; go to DONE.
  - DONE (one cycle): rx <= received byte, rx_valid <= 1. If rx_valid was already 1 and is not being cleared by a DATA_IN read on this edge, set overrun. New data always overwrites. Then go to IDLE.
  - busy = (state != IDLE).
- Transfer length: 1 IDLE-exit clock + 16*(DIV+1) SHIFT clocks + 1 DONE clock. Back-to-back transfers have exactly 1 IDLE cycle between DONE and the next SHIFT.
- DATA_IN read on the DONE edge: o_data gets the old rx. rx_valid stays 1 (the new byte). Overrun is not set.
- CTRL/DIV writes while busy: stored immediately, but used only from the next transfer start (SS excepted, see above).
- i_MISO is sampled directly, with no synchroniser. DIV=0 is legal (SCLK = CLK/2).

Test Plan:
1. Mode 0, DIV=1, SS enable, index 0, write 0xA5, slave returns 0x3C → o_SS_bar=0; MOSI bits 1,0,1,0,0,1,0,1 on the rising edges; 8 rising edges, 2 clocks per half-period; busy high for 33 clocks; STATUS=0x04; DATA_IN read=0x3C; STATUS then 0x00.
2. Mode 3, LSB-first, DIV=0, write 0x81, MISO loopback → SCLK idles high; first MOSI bit 1 changes on the first (falling) edge; rx=0x81.
3. Back-to-back: write 0x11, then 0x22 while busy → tx_full=1 until the first transfer ends; one IDLE cycle gap; SS stays low throughout; a third write while tx_full is dropped; DATA_IN returns 0x22 with overrun=1; writing STATUS with 0x08 clears overrun.
4. Slave select: NUM_SS=4, index 3 → o_SS_bar=0111; index 5 → 1111; SS enable=0 → 1111.
5. Reset mid-transfer: assert i_rst_n=0 at tick 7 → all outputs and registers return to reset values asynchronously; rx_valid=0; DIV=23 for the default parameters.
6. Change DIV from 1 to 3 mid-transfer → current transfer keeps 2-clock half-periods; next transfer uses 4.
